// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to
// instruction memory, and produces the IF/ID pipeline register for decode.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall_flag,
    input  logic        take_branch,
    input  logic [31:0] branch_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] if_id_IR,
    output logic [31:0] if_id_PC,
    output logic        if_id_valid_inst
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_hold;
    logic [31:0] w_hold_nxt;
    logic [31:0] r_ir;
    logic [31:0] w_ir_nxt;
    logic [31:0] r_ifpc;
    logic [31:0] w_ifpc_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic        w_handshake;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    // Request is masked during reset so memory never sees a request while rst is high.
    assign imem_req_valid   = (r_state == S_REQ) && !rst;
    assign imem_addr        = r_pc;
    assign if_id_IR         = r_ir;
    assign if_id_PC         = r_ifpc;
    assign if_id_valid_inst = r_valid;

    assign w_handshake = imem_req_valid && imem_req_ready;
    assign w_target    = branch_target & 32'hFFFF_FFFC;
    assign w_pc_inc    = r_pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_hold  <= 32'd0;
            r_ir    <= NOP_INST;
            r_ifpc  <= 32'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_hold  <= w_hold_nxt;
            r_ir    <= w_ir_nxt;
            r_ifpc  <= w_ifpc_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Default IF/ID behaviour: hold under stall, otherwise a bubble unless a delivery overrides it.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_hold_nxt  = r_hold;
        w_ifpc_nxt  = r_ifpc;
        if (id_stall_flag) begin
            w_ir_nxt    = r_ir;
            w_valid_nxt = r_valid;
        end else begin
            w_ir_nxt    = NOP_INST;
            w_valid_nxt = 1'b0;
        end

        if (take_branch) begin
            w_pc_nxt    = w_target;
            w_ir_nxt    = NOP_INST;
            w_valid_nxt = 1'b0;
            w_hold_nxt  = 32'd0;
            case (r_state)
                S_REQ:   w_state_nxt = w_handshake ? S_DROP : S_REQ;
                S_WAIT:  w_state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
                S_HOLD:  w_state_nxt = S_REQ;
                default: w_state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_handshake) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid && !id_stall_flag) begin
                        w_ir_nxt    = imem_rsp_data;
                        w_ifpc_nxt  = r_pc;
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = S_REQ;
                    end else if (imem_rsp_valid) begin
                        w_hold_nxt  = imem_rsp_data;
                        w_state_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!id_stall_flag) begin
                        w_ir_nxt    = r_hold;
                        w_ifpc_nxt  = r_pc;
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = S_REQ;
                    end
                end
                default: begin
                    if (imem_rsp_valid) begin
                        w_state_nxt = S_REQ;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed bench for if_stage_fetch: two instances (RESET_PC 0 and 0xFFFF_FFFC)
// share stimulus, with the second held in reset until the wrap scenario.
module tb_if_stage_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst0;
   logic        rst1;
   logic        stall;
   logic        takeBranch;
   logic [31:0] branchTarget;
   logic        reqReady;
   logic        rspValid;
   logic [31:0] rspData;

   logic        reqValid0;
   logic [31:0] addr0;
   logic [31:0] ir0;
   logic [31:0] pc0;
   logic        valid0;
   logic        reqValid1;
   logic [31:0] addr1;
   logic [31:0] ir1;
   logic [31:0] pc1;
   logic        valid1;

   int checkCount = 0;
   int failCount  = 0;
   logic outstanding = 1'b0;

   if_stage_fetch dut0 (
      .clk              (clk),
      .rst              (rst0),
      .id_stall_flag    (stall),
      .take_branch      (takeBranch),
      .branch_target    (branchTarget),
      .imem_req_valid   (reqValid0),
      .imem_req_ready   (reqReady),
      .imem_addr        (addr0),
      .imem_rsp_valid   (rspValid),
      .imem_rsp_data    (rspData),
      .if_id_IR         (ir0),
      .if_id_PC         (pc0),
      .if_id_valid_inst (valid0)
   );

   if_stage_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
      .clk              (clk),
      .rst              (rst1),
      .id_stall_flag    (stall),
      .take_branch      (takeBranch),
      .branch_target    (branchTarget),
      .imem_req_valid   (reqValid1),
      .imem_req_ready   (reqReady),
      .imem_addr        (addr1),
      .imem_rsp_valid   (rspValid),
      .imem_rsp_data    (rspData),
      .if_id_IR         (ir1),
      .if_id_PC         (pc1),
      .if_id_valid_inst (valid1)
   );

   // Free-running 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // A response with no accepted request outstanding is a protocol violation.
   always @(posedge clk) begin
      assert (!(rspValid && !outstanding))
         else $error("[TB] protocol violation: response with no outstanding request");
      if (rspValid)
         outstanding <= 1'b0;
      else if ((reqValid0 || reqValid1) && reqReady)
         outstanding <= 1'b1;
   end

   // Absolute time bound so the run always ends even if the sequence stalls.
   initial begin
      #100000;
      $display("[TB] FAIL timeout: observed no finish expected finish before 100000");
      $fatal(1, "[TB] timeout");
   end

   function automatic logic [31:0] instAt(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic st, input logic br, input logic [31:0] tgt,
                                input logic rdy, input logic rv, input logic [31:0] rd);
      stall        = st;
      takeBranch   = br;
      branchTarget = tgt;
      reqReady     = rdy;
      rspValid     = rv;
      rspData      = rd;
   endtask

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp)
         else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
         end
   endtask

   // Compares dut0's request channel and IF/ID; the IF/ID PC is only checked for real instructions.
   task automatic checkOutput(input string tag, input logic expReq, input logic [31:0] expAddr,
                              input logic [31:0] expIr, input logic [31:0] expPc, input logic expValid);
      checkValue({tag, ".req"},   {31'd0, reqValid0}, {31'd0, expReq});
      checkValue({tag, ".addr"},  addr0, expAddr);
      checkValue({tag, ".ir"},    ir0, expIr);
      checkValue({tag, ".valid"}, {31'd0, valid0}, {31'd0, expValid});
      if (expValid)
         checkValue({tag, ".pc"}, pc0, expPc);
   endtask

   initial begin
      rst0 = 1'b0;
      rst1 = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      #1;
      rst0 = 1'b1;
      rst1 = 1'b1;
      tick();
      tick();
      checkOutput("reset", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
      checkValue("reset.pc", pc0, 32'h0);

      // Release reset: request to RESET_PC appears immediately.
      rst0 = 1'b0;
      #1;
      checkOutput("release", 1'b1, 32'h0, NOP, 32'h0, 1'b0);

      tick();
      checkOutput("wait0", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, instAt(32'h0));

      tick();
      checkOutput("deliver0", 1'b1, 32'h4, instAt(32'h0), 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);

      // Stall raised one cycle before the response of 0x4 and held for three cycles.
      tick();
      checkOutput("stallA", 1'b0, 32'h4, instAt(32'h0), 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, instAt(32'h4));

      tick();
      checkOutput("stallB", 1'b0, 32'h4, instAt(32'h0), 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);

      tick();
      checkOutput("stallC", 1'b0, 32'h4, instAt(32'h0), 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);

      tick();
      checkOutput("holdRelease", 1'b1, 32'h8, instAt(32'h4), 32'h4, 1'b1);

      // Redirect while the 0x8 request is outstanding.
      tick();
      checkOutput("wait8", 1'b0, 32'h8, NOP, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'h103, 1'b1, 1'b0, 32'd0);

      tick();
      checkOutput("branchWait", 1'b0, 32'h100, NOP, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, instAt(32'h8));

      tick();
      checkOutput("dropRsp", 1'b1, 32'h100, NOP, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);

      // Branch with stall while holding fetched data.
      tick();
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, instAt(32'h100));
      tick();
      checkOutput("hold100", 1'b0, 32'h100, NOP, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'd0);

      tick();
      checkOutput("branchHold", 1'b1, 32'h200, NOP, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

      tick();
      checkOutput("holdDiscarded", 1'b1, 32'h200, NOP, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 32'd0);

      // Backpressure at 0x20, then redirect to 0x40 without a handshake.
      tick();
      checkOutput("bp1", 1'b1, 32'h20, NOP, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

      tick();
      checkOutput("bp2", 1'b1, 32'h20, NOP, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'd0);

      tick();
      checkOutput("bp3", 1'b1, 32'h40, NOP, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

      tick();
      checkOutput("bp4", 1'b1, 32'h40, NOP, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);

      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, instAt(32'h40));
      tick();
      checkOutput("deliver40", 1'b1, 32'h44, instAt(32'h40), 32'h40, 1'b1);
      applyStimulus(1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 32'd0);

      // Redirect in the same cycle a request is accepted: the old response must be dropped.
      tick();
      checkOutput("branchReqHs", 1'b0, 32'h80, NOP, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, instAt(32'h44));

      tick();
      checkOutput("drop44", 1'b1, 32'h80, NOP, 32'h0, 1'b0);

      // Asynchronous reset of dut0 and release of the wrapping instance.
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      rst0 = 1'b1;
      rst1 = 1'b0;
      #1;
      checkOutput("asyncRst0", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
      checkValue("asyncRst0.pc", pc0, 32'h0);
      checkValue("wrap.addr0", addr1, 32'hFFFF_FFFC);
      checkValue("wrap.req0", {31'd0, reqValid1}, 32'd1);

      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, instAt(32'hFFFF_FFFC));
      tick();
      checkValue("wrap.ir",    ir1, instAt(32'hFFFF_FFFC));
      checkValue("wrap.pc",    pc1, 32'hFFFF_FFFC);
      checkValue("wrap.valid", {31'd0, valid1}, 32'd1);
      checkValue("wrap.addr",  addr1, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);

      tick();
      checkValue("wrapWait.req", {31'd0, reqValid1}, 32'd0);
      checkValue("wrapWait.ir",  ir1, instAt(32'hFFFF_FFFC));

      // Reset mid-WAIT must clear everything before the next clock edge.
      #2;
      rst1 = 1'b1;
      #1;
      checkValue("rstWait.req",   {31'd0, reqValid1}, 32'd0);
      checkValue("rstWait.addr",  addr1, 32'hFFFF_FFFC);
      checkValue("rstWait.ir",    ir1, NOP);
      checkValue("rstWait.pc",    pc1, 32'h0);
      checkValue("rstWait.valid", {31'd0, valid1}, 32'd0);

      $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
      $finish;
   end

endmodule
